processor_gen: RTL and testbench
================================

# processor_gen

Parametrised multi-cycle processor core, the successor of the fixed 16-bit, 4-register design. It generalises data width and register count and makes PC a register-bank entry. It adds a memory wait-state handshake, a conditional move driven by the last ALU result, and a halt state. The core sits between instruction/data memory (through `addr_out`/`data_in`/`data_out`/`Wr`) and the board-level debug outputs.

## Interface
- `W`, 16: datapath and instruction width; must satisfy W ≥ 3 + 2·log2(NREGS).
- `NREGS`, 8: register count, a power of 2 and ≥ 4. Register NREGS-1 is the PC. RW = log2(NREGS).
- `Clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the rising edge of `Clock`.
- `run`  in  1  when 0, the FSM and all registers hold.
- `data_in`  in  W  memory read data.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `addr_out`  out  W  memory address register.
- `data_out`  out  W  memory write data register.
- `Wr`  out  1  memory write strobe (registered).
- `done`  out  1  one-cycle pulse per retired instruction.
- `halted`  out  1  core is in HALT.
- `regs_flat`  out  NREGS·W  register bank; Rk occupies bits [k·W +: W].

## Operation
- Instruction fields: opcode = instr[W-1:W-3], Rx = instr[W-4 -: RW], Ry = the next RW bits. Remaining bits are ignored.
- Opcodes:
  - 0 mv: Rx←Ry.
  - 1 mvi: Rx←next word.
  - 2 add: Rx←Rx+Ry, G updated.
  - 3 sub: Rx←Rx−Ry, G updated.
  - 4 ld: Rx←mem[Ry].
  - 5 st: mem[Ry]←Rx.
  - 6 mvnz: if G≠0 then Rx←Ry.
  - 7 halt.
- Internal registers: IR (W bits), A (W bits), G (W bits). Arithmetic is modulo 2^W; carry and borrow are discarded.
- FSM states: F0, F1, E1, E2, E3, HALT.
  - F0: ADDR←PC, PC←PC+1. Next state F1.
  - F1: if mem_ready, IR←data_in and go to E1; otherwise stay in F1.
  - E1, by opcode:
    - mv: write Rx; retire.
    - mvnz: conditional write of Rx; retire.
    - mvi: ADDR←PC, PC←PC+1; go to E2.
    - add/sub: A←Rx; go to E2.
    - ld: ADDR←Ry; go to E2.
    - st: ADDR←Ry, DOUT←Rx, Wr←1; go to E2.
    - halt: go to HALT.
  - E2, by opcode:
    - mvi/ld: stay until mem_ready, then Rx←data_in; retire.
    - st: stay until mem_ready, then Wr←0; retire.
    - add/sub: G←A±Ry; go to E3.
  - E3: Rx←G; retire.
  - Retire: `done`←1 for the following cycle; state returns to F0.
- Writing Rx = PC is a jump. Reads of PC return the already-incremented value. No cycle both increments PC and writes it.
- HALT is absorbing: `halted`=1, no memory access, all registers hold. Only reset exits HALT.
- run=0 freezes everything, including `done`, `Wr`, and the mem_ready sampling; mem_ready is ignored while run=0.
- Reset takes priority over run. Reset values: every register 0, PC 0, IR/A/G 0, `addr_out` 0, `data_out` 0, `Wr` 0, `done` 0, `halted` 0, state F0.
- Reset asserted mid-access aborts the access and drops `Wr` on that edge.

## Timing
- Zero-wait-state latency, counted as edges from F0 entry to retirement:
  - mv, mvnz: 3.
  - mvi, ld, st: 4.
  - add, sub: 5.
- Each cycle with mem_ready=0 in F1 or E2 adds exactly one cycle.
- `addr_out` is stable for the whole access, from the edge that loads it until mem_ready is sampled 1.
- `Wr` rises on the E1 edge. It falls on the edge that samples mem_ready=1 in E2.
- `done` is high for exactly one cycle, the cycle after the retiring edge; the next F0 occupies that same cycle.
- mem_ready=1 outside F1/E2 has no effect.

## Test plan
All scenarios use W=16, NREGS=8, with Rx at bits 12:10 and Ry at bits 9:7.
- Hold reset=0 for one edge in the middle of an add → all outputs 0, and the first fetch after release drives addr_out=0.
- mem_ready tied 1; program 0x2000, 0x0005 (mvi R0,#5) → R0=5 and PC=2 after 4 edges; one `done` pulse.
- R0=5, R1=0xFFFE; run add R0,R1 (0x4080) → R0=0x0003, G=3. Then sub R0,R0 (0x6000) → R0=0, G=0. Then mvnz R2,R0 (0xC800) → R2 unchanged. Repeat mvnz with G≠0 → R2=R0.
- st R1,[R2] (0xA500) with R1=0x1234, R2=0x0040, mem_ready low for 3 cycles in E2 → addr_out=0x0040 and data_out=0x1234 held; Wr high for exactly 4 cycles; latency 7 edges.
- Drop run for 5 cycles during F1 of an ld, toggling mem_ready → no state change. After run returns, the instruction completes with the same result and latency +0 relative to run-high cycles.
- halt (0xE000) → `halted`=1 after the E1 edge; addr_out frozen and no further `done`. Reset low returns the core to F0 with PC=0.

Source files
------------

// File: rtl/processor_gen.sv
// processor_gen: parametrised multi-cycle core. Fetch/execute FSM around a
// register bank whose top entry is the PC, with a mem_ready wait-state
// handshake, a G-conditioned move and an absorbing HALT state.
module processor_gen #(
    parameter int W     = 16,
    parameter int NREGS = 8
) (
    input  logic               Clock,
    input  logic               reset,
    input  logic               run,
    input  logic [W-1:0]       data_in,
    input  logic               mem_ready,
    output logic [W-1:0]       addr_out,
    output logic [W-1:0]       data_out,
    output logic               Wr,
    output logic               done,
    output logic               halted,
    output logic [NREGS*W-1:0] regs_flat
);
    localparam int RW  = $clog2(NREGS);
    // Only the decoded fields of the instruction are kept; the low bits are don't-care.
    localparam int IRW = 3 + 2 * RW;
    localparam logic [RW-1:0] PC_IDX = RW'(NREGS - 1);

    localparam logic [2:0] S_F0   = 3'd0;
    localparam logic [2:0] S_F1   = 3'd1;
    localparam logic [2:0] S_E1   = 3'd2;
    localparam logic [2:0] S_E2   = 3'd3;
    localparam logic [2:0] S_E3   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    localparam logic [2:0] OP_MV   = 3'd0;
    localparam logic [2:0] OP_MVI  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_LD   = 3'd4;
    localparam logic [2:0] OP_ST   = 3'd5;
    localparam logic [2:0] OP_MVNZ = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    logic [2:0]     state;
    logic [W-1:0]   regs [NREGS];
    logic [IRW-1:0] ir;
    logic [W-1:0]   a;
    logic [W-1:0]   g;

    logic [2:0]    op;
    logic [RW-1:0] rx;
    logic [RW-1:0] ry;
    logic [W-1:0]  rx_val;
    logic [W-1:0]  ry_val;

    assign op     = ir[IRW-1 -: 3];
    assign rx     = ir[IRW-4 -: RW];
    assign ry     = ir[IRW-4-RW -: RW];
    assign rx_val = regs[rx];
    assign ry_val = regs[ry];

    for (genvar k = 0; k < NREGS; k++) begin : g_flat
        assign regs_flat[k*W +: W] = regs[k];
    end

    // Whole core state: reset first, then everything gated by run.
    always_ff @(posedge Clock) begin
        if (!reset) begin
            state <= S_F0;
            for (int k = 0; k < NREGS; k++) regs[k] <= '0;
            ir       <= '0;
            a        <= '0;
            g        <= '0;
            addr_out <= '0;
            data_out <= '0;
            Wr       <= 1'b0;
            done     <= 1'b0;
            halted   <= 1'b0;
        end else if (run) begin
            // done is a single-cycle pulse; any retire below re-asserts it.
            done <= 1'b0;
            case (state)
                S_F0: begin
                    addr_out     <= regs[PC_IDX];
                    regs[PC_IDX] <= regs[PC_IDX] + W'(1);
                    state        <= S_F1;
                end
                S_F1: begin
                    if (mem_ready) begin
                        ir    <= data_in[W-1 -: IRW];
                        state <= S_E1;
                    end
                end
                S_E1: begin
                    case (op)
                        OP_MV: begin
                            regs[rx] <= ry_val;
                            done     <= 1'b1;
                            state    <= S_F0;
                        end
                        OP_MVNZ: begin
                            if (g != '0) regs[rx] <= ry_val;
                            done  <= 1'b1;
                            state <= S_F0;
                        end
                        OP_MVI: begin
                            addr_out     <= regs[PC_IDX];
                            regs[PC_IDX] <= regs[PC_IDX] + W'(1);
                            state        <= S_E2;
                        end
                        OP_ADD, OP_SUB: begin
                            a     <= rx_val;
                            state <= S_E2;
                        end
                        OP_LD: begin
                            addr_out <= ry_val;
                            state    <= S_E2;
                        end
                        OP_ST: begin
                            addr_out <= ry_val;
                            data_out <= rx_val;
                            Wr       <= 1'b1;
                            state    <= S_E2;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        default: state <= S_F0;
                    endcase
                end
                S_E2: begin
                    case (op)
                        OP_ADD: begin
                            g     <= a + ry_val;
                            state <= S_E3;
                        end
                        OP_SUB: begin
                            g     <= a - ry_val;
                            state <= S_E3;
                        end
                        OP_ST: begin
                            if (mem_ready) begin
                                Wr    <= 1'b0;
                                done  <= 1'b1;
                                state <= S_F0;
                            end
                        end
                        OP_MVI, OP_LD: begin
                            if (mem_ready) begin
                                regs[rx] <= data_in;
                                done     <= 1'b1;
                                state    <= S_F0;
                            end
                        end
                        default: state <= S_F0;
                    endcase
                end
                S_E3: begin
                    regs[rx] <= g;
                    done     <= 1'b1;
                    state    <= S_F0;
                end
                S_HALT: ;
                default: state <= S_F0;
            endcase
        end
    end
endmodule

// File: tb/tb_processor_gen.sv
// Bench for processor_gen: instruction-level reference model with memory
// access waits, compared every cycle, plus directed literal checks.
module tb_processor_gen;
    localparam int W     = 16;
    localparam int NREGS = 8;

    logic               Clock = 1'b0;
    logic               reset, run, mem_ready;
    logic [W-1:0]       data_in, addr_out, data_out;
    logic               Wr, done, halted;
    logic [NREGS*W-1:0] regs_flat;

    logic [15:0] mem [0:65535];
    int  vectors = 0;
    int  miscompares = 0;
    bit  chk_en = 0;

    // reference model state
    logic [15:0] m_regs [NREGS];
    logic [15:0] m_g, m_addr, m_dout;
    bit          m_wr, m_done, m_halted;

    processor_gen #(.W(W), .NREGS(NREGS)) dut (
        .Clock(Clock), .reset(reset), .run(run), .data_in(data_in),
        .mem_ready(mem_ready), .addr_out(addr_out), .data_out(data_out),
        .Wr(Wr), .done(done), .halted(halted), .regs_flat(regs_flat)
    );

    always #5 Clock = ~Clock;

    assign data_in = mem[addr_out];

    // memory completes a write when the core strobes and the access is acknowledged
    always @(posedge Clock)
        if (reset && run && Wr && mem_ready) mem[addr_out] = data_out;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] R(input int k);
        return regs_flat[k*W +: W];
    endfunction

    // ---------------- reference model ----------------
    // One effective clock edge: skips frozen (run=0) edges; reset wipes state.
    task automatic tick(output bit ab);
        do @(posedge Clock); while (reset && !run);
        ab = !reset;
        if (ab) begin
            for (int k = 0; k < NREGS; k++) m_regs[k] = '0;
            m_g = '0; m_addr = '0; m_dout = '0;
            m_wr = 0; m_done = 0; m_halted = 0;
        end else m_done = 0;
    endtask

    // Edges until memory acknowledges the pending access.
    task automatic wait_mem(output bit ab);
        do tick(ab); while (!ab && !mem_ready);
    endtask

    task automatic exec(output bit ab);
        logic [15:0] ins;
        int op, rx, ry;
        tick(ab); if (ab) return;
        m_addr = m_regs[7]; m_regs[7] = m_regs[7] + 16'd1;
        wait_mem(ab); if (ab) return;
        ins = mem[m_addr];
        op = int'(ins[15:13]); rx = int'(ins[12:10]); ry = int'(ins[9:7]);
        tick(ab); if (ab) return;
        case (op)
            0: begin m_regs[rx] = m_regs[ry]; m_done = 1; end
            6: begin if (m_g != 0) m_regs[rx] = m_regs[ry]; m_done = 1; end
            1: begin
                m_addr = m_regs[7]; m_regs[7] = m_regs[7] + 16'd1;
                wait_mem(ab); if (ab) return;
                m_regs[rx] = mem[m_addr]; m_done = 1;
            end
            4: begin
                m_addr = m_regs[ry];
                wait_mem(ab); if (ab) return;
                m_regs[rx] = mem[m_addr]; m_done = 1;
            end
            5: begin
                m_addr = m_regs[ry]; m_dout = m_regs[rx]; m_wr = 1;
                wait_mem(ab); if (ab) return;
                m_wr = 0; m_done = 1;
            end
            2, 3: begin
                tick(ab); if (ab) return;
                m_g = (op == 2) ? m_regs[rx] + m_regs[ry] : m_regs[rx] - m_regs[ry];
                tick(ab); if (ab) return;
                m_regs[rx] = m_g; m_done = 1;
            end
            default: begin
                m_halted = 1;
                do tick(ab); while (!ab);
            end
        endcase
    endtask

    initial begin
        bit ab;
        forever exec(ab);
    end

    // every-cycle comparison against the model
    always @(negedge Clock) begin
        logic [NREGS*W-1:0] exp_regs;
        if (chk_en) begin
            for (int k = 0; k < NREGS; k++) exp_regs[k*W +: W] = m_regs[k];
            chk("regs", regs_flat, exp_regs);
            chk("addr_out", addr_out, m_addr);
            chk("data_out", data_out, m_dout);
            chk("Wr", Wr, m_wr);
            chk("done", done, m_done);
            chk("halted", halted, m_halted);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge Clock); #2;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin step(); n++; end while (!done && n < 200);
        chk("done_seen", done, 1'b1);
    endtask

    initial begin
        int n, wrcnt, stalls;
        logic [15:0] w;
        reset = 0; run = 1; mem_ready = 1;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        // directed program
        mem[0]  = 16'h2000; mem[1]  = 16'h0005;   // mvi R0,5
        mem[2]  = 16'h2400; mem[3]  = 16'hFFFE;   // mvi R1,FFFE
        mem[4]  = 16'h2800; mem[5]  = 16'h0040;   // mvi R2,40
        mem[6]  = 16'h4080;                       // add R0,R1
        mem[7]  = 16'h6000;                       // sub R0,R0
        mem[8]  = 16'hC800;                       // mvnz R2,R0 (G=0)
        mem[9]  = 16'h2000; mem[10] = 16'h0007;   // mvi R0,7
        mem[11] = 16'h4080;                       // add R0,R1 -> 5
        mem[12] = 16'hC800;                       // mvnz R2,R0 (G=5)
        mem[13] = 16'h2800; mem[14] = 16'h0040;   // mvi R2,40
        mem[15] = 16'h2400; mem[16] = 16'h1234;   // mvi R1,1234
        mem[17] = 16'hA500;                       // st R1,[R2]
        mem[18] = 16'h8D00;                       // ld R3,[R2]
        mem[19] = 16'hE000;                       // halt

        step(); chk_en = 1; step();
        chk("rst_regs", regs_flat, '0);
        chk("rst_addr", addr_out, 16'h0);
        chk("rst_wr", Wr, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_halted", halted, 1'b0);
        reset = 1;

        wait_done(n);
        chk("mvi_lat", n, 4); chk("mvi_r0", R(0), 16'h0005); chk("mvi_pc", R(7), 16'h0002);
        wait_done(n); wait_done(n);
        wait_done(n); chk("add_lat", n, 5); chk("add_r0", R(0), 16'h0003);
        wait_done(n); chk("sub_r0", R(0), 16'h0000);
        wait_done(n); chk("mvnz_lat", n, 3); chk("mvnz_g0_r2", R(2), 16'h0040);
        wait_done(n); wait_done(n); chk("add2_r0", R(0), 16'h0005);
        wait_done(n); chk("mvnz_g5_r2", R(2), 16'h0005);
        wait_done(n); wait_done(n); chk("r1_1234", R(1), 16'h1234);

        // st with three wait states in E2
        n = 0; wrcnt = 0; stalls = 0;
        do begin
            step(); n++;
            if (Wr) begin
                wrcnt++;
                chk("st_addr", addr_out, 16'h0040);
                chk("st_dout", data_out, 16'h1234);
                if (stalls < 3) begin mem_ready = 0; stalls++; end
                else mem_ready = 1;
            end
        end while (!done && n < 50);
        mem_ready = 1;
        chk("st_lat", n, 7); chk("st_wr_cycles", wrcnt, 4); chk("st_mem", mem[16'h0040], 16'h1234);

        // ld with run dropped for five cycles in F1
        step();
        run = 0;
        for (int i = 0; i < 5; i++) begin mem_ready = i[0]; step(); end
        run = 1; mem_ready = 1;
        wait_done(n);
        chk("ld_lat", n + 6, 9); chk("ld_r3", R(3), 16'h1234);

        // halt
        step(); step(); step();
        chk("halted", halted, 1'b1);
        n = 0;
        for (int i = 0; i < 10; i++) begin step(); if (done) n++; end
        chk("halt_addr", addr_out, 16'd19); chk("halt_no_done", n, 0);
        reset = 0; step(); reset = 1;
        chk("unhalt", halted, 1'b0); chk("unhalt_pc", R(7), 16'h0000);

        // reset in the middle of an add
        wait_done(n); wait_done(n); wait_done(n);
        step(); step(); step();
        reset = 0; step(); reset = 1;
        chk("midadd_regs", regs_flat, '0); chk("midadd_addr", addr_out, 16'h0);
        chk("midadd_wr", Wr, 1'b0); chk("midadd_done", done, 1'b0);
        step();
        chk("refetch_addr", addr_out, 16'h0000); chk("refetch_pc", R(7), 16'h0001);

        // randomized program, wait states, run gaps and resets
        reset = 0;
        for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom);
            if (w[15:13] == 3'd7 && $urandom_range(7, 0) != 0) w[15:13] = 3'd0;
            mem[i] = w;
        end
        step(); reset = 1;
        for (int c = 0; c < 5000; c++) begin
            run       = ($urandom_range(9, 0) != 0);
            mem_ready = ($urandom_range(2, 0) != 0);
            reset     = ($urandom_range(399, 0) != 0);
            step();
        end
        reset = 1; run = 1; mem_ready = 1;
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
